// File: rtl/alpharetz_uart_tx_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the UART transmitter.
// master: requester/transmitter side; slave: the arbiter itself.
interface alpharetz_uart_tx_arb_if #(
    parameter int NUM_REQ         = 4,
    parameter int UART_DATA_WIDTH = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*UART_DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [UART_DATA_WIDTH-1:0]         tx_data;
    logic                               start_tx;
    logic                               tx_busy;
    logic [GW-1:0]                      grant_id;
    logic                               active;
    logic                               timeout_err;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, start_tx, grant_id, active, timeout_err
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, start_tx, grant_id, active, timeout_err
    );
endinterface

// File: rtl/alpharetz_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters,
// with a start-timeout watchdog so a stuck transmitter cannot hang the bus.
module alpharetz_uart_tx_arb #(
    parameter int NUM_REQ         = 4,
    parameter int UART_DATA_WIDTH = 8,
    parameter int START_TIMEOUT   = 64
) (
    input logic sys_clk,
    input logic sync_rst_n,
    input logic sys_clk_en,
    alpharetz_uart_tx_arb_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [GW-1:0]              last_grant_q, last_grant_d;
    logic [GW-1:0]              grant_id_q, grant_id_d;
    logic [UART_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic [GW-1:0]              winner;
    logic                       any_valid;
    logic [UART_DATA_WIDTH-1:0] win_data;
    logic                       fire;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin : rr_pick
        int            idx;
        logic [GW-1:0] cand;
        idx       = 0;
        cand      = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = GW'(idx);
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin : data_mux
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i))
                win_data = bus.req_data[i*UART_DATA_WIDTH +: UART_DATA_WIDTH];
        end
    end

    assign fire = sys_clk_en & sync_rst_n;

    always_comb begin : fsm_next
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        bus.req_ready = '0;
        bus.start_tx  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    bus.req_ready[winner] = fire;
                    grant_id_d = winner;
                    tx_data_d  = win_data;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.start_tx = fire;
                cnt_d        = '0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    // Release the grant too, so a dead requester cannot starve others.
                    state_d      = IDLE;
                    err_d        = 1'b1;
                    last_grant_d = grant_id_q;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else if (sys_clk_en) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.active      = sync_rst_n & (state_q != IDLE);
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_alpharetz_uart_tx_arb.sv
// Bench for the UART transmit arbiter: directed and randomized transactions
// checked against a transaction-level round-robin / latency model.
module tb_alpharetz_uart_tx_arb;
    logic clk = 1'b0;
    logic rst_n;
    logic en;
    bit   gate;
    int   passed;
    int   total;
    int   last_m;
    bit   err_m;

    alpharetz_uart_tx_arb_if #(.NUM_REQ(4), .UART_DATA_WIDTH(8)) bus ();

    alpharetz_uart_tx_arb #(
        .NUM_REQ(4),
        .UART_DATA_WIDTH(8),
        .START_TIMEOUT(64)
    ) dut (
        .sys_clk   (clk),
        .sync_rst_n(rst_n),
        .sys_clk_en(en),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++)
            if (mask[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // One enabled cycle; in gated mode a disabled cycle is inserted after it.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (gate) begin
            en = 1'b0;
            #1;
            chk("gated_ready", 32'(bus.req_ready), 32'd0);
            chk("gated_start", 32'(bus.start_tx), 32'd0);
            @(posedge clk);
            @(negedge clk);
            en = 1'b1;
        end
        #1;
    endtask

    // d: WAIT_BUSY cycle index where busy rises (>=64 means never);
    // blen: busy length in cycles.
    task automatic run_txn(input logic [3:0] mask, input logic [31:0] data,
                           input int d, input int blen, input bit busy_launch);
        int w;
        int n;
        bit to;
        logic [7:0] byte_exp;
        bus.req_valid = mask;
        bus.req_data  = data;
        bus.tx_busy   = 1'b0;
        #1;
        if (mask == 4'd0) begin
            chk("idle_ready", 32'(bus.req_ready), 32'd0);
            chk("idle_active", 32'(bus.active), 32'd0);
            tick();
            return;
        end
        w = rr_pick(last_m, mask);
        byte_exp = data[w*8 +: 8];
        chk("accept_ready", 32'(bus.req_ready), 32'(1 << w));
        chk("accept_active", 32'(bus.active), 32'd0);
        chk("accept_start", 32'(bus.start_tx), 32'd0);
        tick();
        bus.req_data  = $urandom;
        bus.req_valid = 4'($urandom);
        bus.tx_busy   = busy_launch;
        #1;
        chk("launch_start", 32'(bus.start_tx), 32'd1);
        chk("launch_ready", 32'(bus.req_ready), 32'd0);
        chk("launch_gid", 32'(bus.grant_id), 32'(w));
        chk("launch_data", 32'(bus.tx_data), 32'(byte_exp));
        chk("launch_active", 32'(bus.active), 32'd1);
        tick();
        to = (d >= 64);
        n  = to ? 64 : d + blen + 1;
        for (int i = 0; i < n; i++) begin
            bus.tx_busy   = !to && i >= d && i < d + blen;
            bus.req_valid = 4'($urandom);
            bus.req_data  = $urandom;
            #1;
            chk("wait_active", 32'(bus.active), 32'd1);
            chk("wait_start", 32'(bus.start_tx), 32'd0);
            chk("wait_ready", 32'(bus.req_ready), 32'd0);
            chk("wait_gid", 32'(bus.grant_id), 32'(w));
            chk("wait_data", 32'(bus.tx_data), 32'(byte_exp));
            tick();
        end
        bus.tx_busy = 1'b0;
        last_m = w;
        err_m  = err_m | to;
        #1;
        chk("exit_active", 32'(bus.active), 32'd0);
        chk("exit_err", 32'(bus.timeout_err), 32'(err_m));
    endtask

    initial begin
        int w;
        passed = 0;
        total  = 0;
        gate   = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        en     = 1'b1;
        last_m = 3;
        err_m  = 1'b0;
        #1;
        chk("rst_active", 32'(bus.active), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_start", 32'(bus.start_tx), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);

        // single request, requester 2, byte A5
        run_txn(4'b0100, 32'h00A5_0000, 2, 3, 1'b0);

        // fairness with all requesters pending
        for (int i = 0; i < 5; i++)
            run_txn(4'b1111, $urandom, 2, 10, 1'b0);

        // wrap-around between requesters 0 and 3
        for (int i = 0; i < 4; i++)
            run_txn(4'b1001, $urandom, 1, 2, 1'b0);

        // busy rising on the very last allowed cycle, and busy seen only in LAUNCH
        run_txn(4'b0110, $urandom, 63, 2, 1'b0);
        run_txn(4'b0110, $urandom, 5, 1, 1'b1);

        // start timeout, then the next requester is still served
        run_txn(4'b1111, $urandom, 100, 1, 1'b0);
        run_txn(4'b1111, $urandom, 0, 2, 1'b0);

        // clock-enable toggling
        gate = 1'b1;
        for (int i = 0; i < 4; i++)
            run_txn(4'($urandom_range(1, 15)), $urandom, 3, 2, 1'b0);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            gate = bit'($urandom_range(0, 1));
            run_txn(4'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 6),
                    $urandom_range(1, 4), bit'($urandom_range(0, 1)));
        end

        // reset while in WAIT_DONE with the transmitter busy
        gate = 1'b0;
        bus.req_valid = 4'b0010;
        bus.tx_busy   = 1'b0;
        #1;
        w = rr_pick(last_m, 4'b0010);
        chk("pre_rst_ready", 32'(bus.req_ready), 32'(1 << w));
        tick();
        chk("pre_rst_start", 32'(bus.start_tx), 32'd1);
        bus.tx_busy = 1'b1;
        tick();
        tick();
        chk("pre_rst_active", 32'(bus.active), 32'd1);
        rst_n = 1'b0;
        en    = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("in_rst_active", 32'(bus.active), 32'd0);
        chk("in_rst_start", 32'(bus.start_tx), 32'd0);
        chk("in_rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst2_active", 32'(bus.active), 32'd0);
        chk("rst2_start", 32'(bus.start_tx), 32'd0);
        rst_n  = 1'b1;
        en     = 1'b1;
        last_m = 3;
        err_m  = 1'b0;
        #1;
        chk("post_rst_err", 32'(bus.timeout_err), 32'd0);
        chk("post_rst_gid", 32'(bus.grant_id), 32'd0);
        chk("post_rst_data", 32'(bus.tx_data), 32'd0);
        run_txn(4'b1010, $urandom, 1, 1, 1'b0);
        run_txn(4'b1010, $urandom, 1, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
